// File: rtl/snake_body_fifo_if.sv
// Segment clear stream: valid/ready handshake carrying {x,y}.
// master drives clr_valid/clr_xy, slave drives clr_ready.
interface snake_body_fifo_if #(
  parameter int W = 11
);
  logic         clr_valid;
  logic         clr_ready;
  logic [W-1:0] clr_xy;

  modport master (
    output clr_valid,
    output clr_xy,
    input  clr_ready
  );

  modport slave (
    input  clr_valid,
    input  clr_xy,
    output clr_ready
  );
endinterface

// File: rtl/snake_body_fifo.sv
// Snake body store: circular FIFO of segment coords plus a clear walk.
// Ports: clk/reset_n, tick/eat/head_xy in, tail/length/full/ovf out,
// clr_req in, clr stream (if), clr_done/busy out.
module snake_body_fifo #(
  parameter int XW    = 6,
  parameter int YW    = 5,
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                eat,
  input  logic [XW+YW-1:0]    head_xy,
  output logic [XW+YW-1:0]    tail_xy,
  output logic                tail_valid,
  output logic [AW-1:0]       length,
  output logic                full,
  output logic                ovf,
  input  logic                clr_req,
  snake_body_fifo_if.master   clr,
  output logic                clr_done,
  output logic                busy
);
  localparam int W  = XW + YW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          we;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  rd_data;

  // DEPTH is not a power of two, so wrap needs an explicit compare
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_data    = mem_q[rd_ptr_q[IW-1:0]];
  assign tail_valid = (len_q != '0);
  assign tail_xy    = tail_valid ? rd_data : '0;
  assign length     = len_q;
  assign full       = (len_q == AW'(DEPTH));
  assign ovf        = ovf_q;
  assign clr.clr_xy = clr.clr_valid ? rd_data : '0;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    len_d         = len_q;
    ovf_d         = ovf_q;
    we            = 1'b0;
    clr.clr_valid = 1'b0;
    clr_done      = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = WALK;
        end else if (tick) begin
          if (eat) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              we       = 1'b1;
              wr_ptr_d = inc(wr_ptr_q);
              len_d    = len_q + 1'b1;
            end
          end else if (tail_valid) begin
            we       = 1'b1;
            wr_ptr_d = inc(wr_ptr_q);
            rd_ptr_d = inc(rd_ptr_q);
          end
        end
      end
      WALK: begin
        busy = 1'b1;
        if (!tail_valid) begin
          state_d = DONE;
        end else begin
          clr.clr_valid = 1'b1;
          if (clr.clr_ready) begin
            rd_ptr_d = inc(rd_ptr_q);
            len_d    = len_q - 1'b1;
            if (len_q == AW'(1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        busy     = 1'b1;
        clr_done = 1'b1;
        wr_ptr_d = rd_ptr_q;
        ovf_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; contents are only read below len_q
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q[IW-1:0]] <= head_xy;
  end
endmodule

// File: tb/tb_snake_body_fifo.sv
// Directed testbench for snake_body_fifo (DEPTH=4 to force wrap/full).
// One task per scenario; inline checks; summary line at end.
module tb_snake_body_fifo;
  localparam int XW = 6, YW = 5, DEPTH = 4, AW = 3;
  localparam int W = XW + YW;

  logic clk = 0, reset_n = 0;
  logic tick = 0, eat = 0, clr_req = 0;
  logic [W-1:0] head_xy = '0, tail_xy;
  logic tail_valid, full, ovf, clr_done, busy;
  logic [AW-1:0] length;
  int tests = 0, fails = 0;

  snake_body_fifo_if #(.W(W)) clr_if ();

  snake_body_fifo #(
    .XW(XW), .YW(YW), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tick(tick), .eat(eat), .head_xy(head_xy),
    .tail_xy(tail_xy), .tail_valid(tail_valid),
    .length(length), .full(full), .ovf(ovf),
    .clr_req(clr_req), .clr(clr_if.master),
    .clr_done(clr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] xy(input int x, input int y);
    return {6'(x), 5'(y)};
  endfunction

  function automatic logic [W-1:0] pat(input int i);
    return {6'(i + 1), 5'(i + 7)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic e, input logic [W-1:0] h);
    tick = 1; eat = e; head_xy = h;
    step();
    tick = 0; eat = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; clr_if.clr_ready = 0;
    step(); step();
    tests++; if (length !== 0) begin fails++; $display("FAIL rst_len got %0d exp 0", length); end
    tests++; if (tail_valid !== 0 || tail_xy !== 0) begin fails++; $display("FAIL rst_tail got %b/%h exp 0/0", tail_valid, tail_xy); end
    tests++; if ({full, ovf, clr_if.clr_valid, clr_done, busy} !== 5'b0) begin fails++; $display("FAIL rst_flags got %b exp 00000", {full, ovf, clr_if.clr_valid, clr_done, busy}); end
    reset_n = 1;
    step();
  endtask

  task automatic test_empty_ticks();
    for (int i = 0; i < 5; i++) do_tick(0, xy(i + 10, i));
    tests++; if (length !== 0) begin fails++; $display("FAIL empty_len got %0d exp 0", length); end
    tests++; if (tail_valid !== 0 || tail_xy !== 0) begin fails++; $display("FAIL empty_tail got %b/%h exp 0/0", tail_valid, tail_xy); end
  endtask

  task automatic test_grow();
    do_tick(1, xy(3, 4));
    do_tick(1, xy(4, 4));
    do_tick(1, xy(5, 4));
    tests++; if (length !== 3) begin fails++; $display("FAIL grow_len got %0d exp 3", length); end
    tests++; if (tail_xy !== xy(3, 4)) begin fails++; $display("FAIL grow_tail got %h exp %h", tail_xy, xy(3, 4)); end
    tick = 1; eat = 0; head_xy = xy(6, 4);
    tests++; if (tail_xy !== xy(3, 4)) begin fails++; $display("FAIL pop_pre_tail got %h exp %h", tail_xy, xy(3, 4)); end
    step();
    tick = 0;
    tests++; if (length !== 3) begin fails++; $display("FAIL pop_len got %0d exp 3", length); end
    tests++; if (tail_xy !== xy(4, 4)) begin fails++; $display("FAIL pop_tail got %h exp %h", tail_xy, xy(4, 4)); end
  endtask

  task automatic test_clear_stall();
    clr_req = 1;
    step();
    clr_req = 0;
    // cycle 1: beat a, accepted; tick during walk must be ignored
    clr_if.clr_ready = 1; tick = 1; eat = 1; head_xy = xy(9, 9);
    tests++; if (busy !== 1 || clr_if.clr_valid !== 1) begin fails++; $display("FAIL walk_start got busy=%b v=%b exp 1/1", busy, clr_if.clr_valid); end
    tests++; if (clr_if.clr_xy !== xy(4, 4)) begin fails++; $display("FAIL beat_a got %h exp %h", clr_if.clr_xy, xy(4, 4)); end
    step();
    tick = 0; eat = 0;
    tests++; if (length !== 2) begin fails++; $display("FAIL walk_len got %0d exp 2", length); end
    clr_if.clr_ready = 0;
    tests++; if (clr_if.clr_xy !== xy(5, 4)) begin fails++; $display("FAIL beat_b got %h exp %h", clr_if.clr_xy, xy(5, 4)); end
    step();
    clr_if.clr_ready = 1;
    tests++; if (clr_if.clr_valid !== 1 || clr_if.clr_xy !== xy(5, 4)) begin fails++; $display("FAIL stall_hold got %b/%h exp 1/%h", clr_if.clr_valid, clr_if.clr_xy, xy(5, 4)); end
    step();
    tests++; if (clr_if.clr_xy !== xy(6, 4)) begin fails++; $display("FAIL beat_c got %h exp %h", clr_if.clr_xy, xy(6, 4)); end
    tests++; if (clr_done !== 0) begin fails++; $display("FAIL done_early got %b exp 0", clr_done); end
    step();
    tests++; if (clr_done !== 1 || clr_if.clr_valid !== 0) begin fails++; $display("FAIL done_pulse got d=%b v=%b exp 1/0", clr_done, clr_if.clr_valid); end
    step();
    tests++; if (clr_done !== 0 || busy !== 0 || length !== 0) begin fails++; $display("FAIL walk_end got d=%b b=%b len=%0d exp 0/0/0", clr_done, busy, length); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) do_tick(1, pat(i));
    tests++; if (length !== 4 || full !== 1) begin fails++; $display("FAIL fill got len=%0d full=%b exp 4/1", length, full); end
    for (int i = 0; i < 10; i++) begin
      tick = 1; eat = 0; head_xy = pat(i + 4);
      tests++; if (tail_xy !== pat(i)) begin fails++; $display("FAIL wrap_tail%0d got %h exp %h", i, tail_xy, pat(i)); end
      step();
    end
    tick = 0;
    tests++; if (length !== 4 || tail_xy !== pat(10)) begin fails++; $display("FAIL wrap_end got len=%0d tail=%h exp 4/%h", length, tail_xy, pat(10)); end
  endtask

  task automatic test_overflow();
    do_tick(1, xy(33, 3));
    tests++; if (length !== 4 || ovf !== 1) begin fails++; $display("FAIL ovf got len=%0d ovf=%b exp 4/1", length, ovf); end
    tests++; if (tail_xy !== pat(10)) begin fails++; $display("FAIL ovf_tail got %h exp %h", tail_xy, pat(10)); end
    clr_if.clr_ready = 1; clr_req = 1;
    step();
    clr_req = 0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (clr_if.clr_valid !== 1 || clr_if.clr_xy !== pat(10 + i)) begin fails++; $display("FAIL full_beat%0d got %b/%h exp 1/%h", i, clr_if.clr_valid, clr_if.clr_xy, pat(10 + i)); end
      step();
    end
    tests++; if (clr_done !== 1) begin fails++; $display("FAIL full_done got %b exp 1", clr_done); end
    step();
    tests++; if (ovf !== 0 || length !== 0 || busy !== 0) begin fails++; $display("FAIL ovf_clear got ovf=%b len=%0d b=%b exp 0/0/0", ovf, length, busy); end
    do_tick(1, xy(20, 20));
    tests++; if (length !== 1 || tail_xy !== xy(20, 20)) begin fails++; $display("FAIL post_clear got len=%0d tail=%h exp 1/%h", length, tail_xy, xy(20, 20)); end
  endtask

  task automatic test_clear_empty();
    clr_req = 1; clr_if.clr_ready = 1;
    step();
    clr_req = 0;
    // drain the single entry so the next walk starts empty
    step(); step(); step();
    tests++; if (length !== 0 || busy !== 0) begin fails++; $display("FAIL pre_empty got len=%0d b=%b exp 0/0", length, busy); end
    clr_req = 1; tick = 1; eat = 1; head_xy = xy(1, 1);
    step();
    clr_req = 0; tick = 0; eat = 0;
    tests++; if (length !== 0) begin fails++; $display("FAIL prio_drop got %0d exp 0", length); end
    tests++; if (busy !== 1 || clr_if.clr_valid !== 0 || clr_done !== 0) begin fails++; $display("FAIL empty_c1 got b=%b v=%b d=%b exp 1/0/0", busy, clr_if.clr_valid, clr_done); end
    step();
    tests++; if (clr_done !== 1) begin fails++; $display("FAIL empty_done got %b exp 1", clr_done); end
    step();
    tests++; if (clr_done !== 0 || busy !== 0) begin fails++; $display("FAIL empty_idle got d=%b b=%b exp 0/0", clr_done, busy); end
  endtask

  task automatic test_reset_mid_walk();
    do_tick(1, xy(7, 7));
    do_tick(1, xy(8, 8));
    clr_if.clr_ready = 0; clr_req = 1;
    step();
    clr_req = 0;
    tests++; if (busy !== 1 || clr_if.clr_valid !== 1) begin fails++; $display("FAIL mid_walk got b=%b v=%b exp 1/1", busy, clr_if.clr_valid); end
    reset_n = 0;
    step();
    tests++; if (busy !== 0 || clr_if.clr_valid !== 0 || length !== 0 || clr_done !== 0) begin fails++; $display("FAIL mid_rst got b=%b v=%b len=%0d d=%b exp 0/0/0/0", busy, clr_if.clr_valid, length, clr_done); end
    reset_n = 1;
    step();
    tests++; if (clr_done !== 0 || busy !== 0) begin fails++; $display("FAIL mid_rst_after got d=%b b=%b exp 0/0", clr_done, busy); end
  endtask

  initial begin
    clr_if.clr_ready = 0;
    test_reset();
    test_empty_ticks();
    test_grow();
    test_clear_stall();
    test_wrap();
    test_overflow();
    test_clear_empty();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
